cast_switch_allocator: RTL and testbench
========================================

Name: cast_switch_allocator

Overview:
- Per-output-port round-robin switch allocator for the multicast NoC router.
- Collects the one-hot output-port requests of every input VC (port × VC) and grants each output port to at most one requester per cycle.
- Drives the crossbar select and the per-VC ready back to the input-port stages.
- Holds a grant until the flit transfer fires, so the crossbar path stays stable while downstream back-pressures.

Parameters:
PN, 5, number of router ports (inputs = outputs)
VN, 2, virtual channels per input port
N, PN*VN, derived requester count; requester index r = in_port*VN + vc

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
req_valid  input  N  requester r has a flit at its FIFO head
req_port  input  N*PN  requester r target-port bitmap at [r*PN +: PN]; one-hot when valid
out_ready  input  PN  downstream of output port p can accept a flit
in_ready  output  N  requester r transfer fires this cycle (ready_i to the input stage)
xbar_sel  output  PN*N  one-hot crossbar select for output p at [p*N +: N]; all-zero = idle
out_valid  output  PN  output port p carries a valid flit this cycle

Behaviour:
- Clock and reset: one clock domain (clk); reset (rst) is asynchronous and active-high.
- Request definition: req[p][r] = req_valid[r] & req_port[r*PN+p].
  - Multi-hot bitmap: only the lowest set bit counts.
  - Zero bitmap with req_valid=1: no request.
- Per-output state:
  - ptr[p]: log2(N)-bit priority pointer.
  - lock[p]: 1 bit.
  - owner[p]: log2(N)-bit current owner.
- Reset (async, while rst=1): ptr=0, lock=0, owner=0. xbar_sel, out_valid and in_ready are forced to 0 for as long as rst is high.
- IDLE (lock=0): combinational round-robin.
  - Winner = first r with req[p][r], scanning ptr[p], ptr[p]+1, … mod N.
  - xbar_sel selects the winner; out_valid[p]=1.
  - No requester: xbar_sel=0, out_valid=0, state unchanged.
- LOCKED (lock=1): grant = owner[p] regardless of other requests. out_valid[p] = req[p][owner].
- Fire rule: fire[p] = out_valid[p] & out_ready[p]. in_ready[r] = 1 iff r is granted on some p and fire[p]=1. Grant-to-fire latency is 0 cycles.
- Next state on each rising edge:
  - Grant without fire: lock<=1, owner<=grant; ptr unchanged.
  - Fire: lock<=0; ptr<=(grant+1) mod N (wraps from N-1 to 0).
  - Locked owner drops its request (protocol violation): lock<=0; ptr unchanged; no fire.
- Simultaneous events:
  - A requester wins at most one output per cycle, because it is one-hot.
  - Different outputs arbitrate independently in the same cycle.
  - New requests arriving while locked wait; they are not reordered.
- Multicast: the input roller advances req_port after each fire. The next port is a fresh request on the following cycle and re-arbitrates.
- Starvation bound: a persistently requesting r is granted within N fires of its port.
- Reset mid-operation: locks and pointers clear immediately. Outputs are 0 while reset is held. Arbitration restarts from requester 0.

Test Plan:
1. Single request, PN=5 VN=2: r=3 requests p=1, out_ready=1. Same cycle: xbar_sel[p1]=bit3, in_ready[3]=1. Next cycle: ptr[1]=4.
2. Contention: r=0,4,7 all request p=2 continuously with out_ready=1. Grants go 0,4,7,0 on consecutive cycles.
3. Back-pressure lock: r=2 granted p=0, out_ready[0]=0 for 3 cycles, r=1 also requests. Grant stays r=2 and in_ready[2]=0 until out_ready rises. Then r=2 fires, and r=1 is granted next.
4. Parallel outputs: r=0→p3 and r=5→p4 in the same cycle, both ready. Both fire at once; pointers update independently (ptr[3]=1, ptr[4]=6).
5. Wrap-around: ptr[1]=9, requests from r=9 and r=0. r=9 wins, then ptr=0 and r=0 wins.
6. Reset mid-lock: lock[0]=1, owner=6, ptr=7; assert rst asynchronously. All outputs go 0 immediately. After release, ptr=0 and the lowest requesting index wins.

Source files
------------

// File: rtl/cast_switch_allocator.sv
// Per-output round-robin switch allocator for the multicast NoC router.
// A grant is held until its flit transfer fires, so the crossbar path stays stable under back-pressure.
module cast_switch_allocator #(
  parameter int PN = 5,
  parameter int VN = 2,
  parameter int N  = PN * VN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [N*PN-1:0]   req_port,
  input  logic [PN-1:0]     out_ready,
  output logic [N-1:0]      in_ready,
  output logic [PN*N-1:0]   xbar_sel,
  output logic [PN-1:0]     out_valid
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t        state_q [PN];
  state_t        state_d [PN];
  logic [PW-1:0] ptr_q   [PN];
  logic [PW-1:0] ptr_d   [PN];
  logic [PW-1:0] owner_q [PN];
  logic [PW-1:0] owner_d [PN];

  logic [N-1:0]  req_m     [PN];
  logic [PW-1:0] grant_idx [PN];
  logic [PN-1:0] grant_hit;
  logic [PN-1:0] fire;
  logic [PW:0]   cand;

  // A multi-hot bitmap counts only through its lowest set bit.
  function automatic logic [PN-1:0] lowest_bit(input logic [PN-1:0] v);
    return v & (~v + PN'(1));
  endfunction

  always_comb begin : req_matrix
    logic [PN-1:0] tgt;
    tgt = '0;
    for (int p = 0; p < PN; p++) req_m[p] = '0;
    for (int r = 0; r < N; r++) begin
      tgt = lowest_bit(req_port[r*PN +: PN]);
      for (int p = 0; p < PN; p++) req_m[p][r] = req_valid[r] & tgt[p];
    end
  end

  // Scan from the far end back toward ptr so the candidate nearest ptr is written last and wins.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no path can infer a latch.
    cand = '0;
    for (int p = 0; p < PN; p++) begin
      grant_hit[p] = 1'b0;
      grant_idx[p] = '0;
      if (state_q[p] == ST_LOCKED) begin
        grant_idx[p] = owner_q[p];
        grant_hit[p] = req_m[p][owner_q[p]];
      end else begin
        for (int k = N - 1; k >= 0; k--) begin
          cand = {1'b0, ptr_q[p]} + (PW+1)'(k);
          if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
          if (req_m[p][cand[PW-1:0]]) begin
            grant_hit[p] = 1'b1;
            grant_idx[p] = cand[PW-1:0];
          end
        end
      end
    end
  end

  // Outputs are gated by rst so they read zero for as long as reset is held.
  always_comb begin
    xbar_sel  = '0;
    in_ready  = '0;
    out_valid = '0;
    fire      = '0;
    for (int p = 0; p < PN; p++) begin
      fire[p] = grant_hit[p] & out_ready[p];
      if (!rst && grant_hit[p]) begin
        out_valid[p]          = 1'b1;
        xbar_sel[p*N +: N]    = N'(1) << grant_idx[p];
        if (out_ready[p]) in_ready[grant_idx[p]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PN; p++) begin
      state_d[p] = state_q[p];
      ptr_d[p]   = ptr_q[p];
      owner_d[p] = owner_q[p];
      if (grant_hit[p]) begin
        if (fire[p]) begin
          state_d[p] = ST_IDLE;
          ptr_d[p]   = (grant_idx[p] == PW'(N - 1)) ? '0 : grant_idx[p] + PW'(1);
        end else begin
          state_d[p] = ST_LOCKED;
          owner_d[p] = grant_idx[p];
        end
      end else if (state_q[p] == ST_LOCKED) begin
        // Locked owner withdrew its request: release without moving the pointer.
        state_d[p] = ST_IDLE;
      end
    end
  end

  // NOTE: state arrays are small flops, not RAM, so each element is reset; sequential updates use <= only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < PN; p++) begin
        state_q[p] <= ST_IDLE;
        ptr_q[p]   <= '0;
        owner_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < PN; p++) begin
        state_q[p] <= state_d[p];
        ptr_q[p]   <= ptr_d[p];
        owner_q[p] <= owner_d[p];
      end
    end
  end

endmodule

// File: tb/tb_cast_switch_allocator.sv
// Self-checking bench for cast_switch_allocator: directed scenarios plus randomized traffic
// compared cycle by cycle against a per-output round-robin reference model.
module tb_cast_switch_allocator;

  localparam int PN = 5;
  localparam int VN = 2;
  localparam int N  = PN * VN;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*PN-1:0]   req_port;
  logic [PN-1:0]     out_ready;
  logic [N-1:0]      in_ready;
  logic [PN*N-1:0]   xbar_sel;
  logic [PN-1:0]     out_valid;

  cast_switch_allocator #(.PN(PN), .VN(VN)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_port  (req_port),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .xbar_sel  (xbar_sel),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: pointer, lock flag and owner per output port.
  int m_ptr   [PN];
  bit m_lock  [PN];
  int m_owner [PN];
  int m_grant [PN];

  logic [PN*N-1:0] obs_xbar;
  logic [N-1:0]    obs_inr;
  logic [PN-1:0]   obs_ov;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Effective target port of requester r, or -1 when it makes no request.
  function automatic int eff_port(int r);
    if (!req_valid[r]) return -1;
    for (int p = 0; p < PN; p++) if (req_port[r*PN + p]) return p;
    return -1;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < PN; p++) begin
      m_ptr[p] = 0; m_lock[p] = 0; m_owner[p] = 0; m_grant[p] = -1;
    end
  endtask

  task automatic model_eval(output logic [PN*N-1:0] ex, output logic [N-1:0] ei,
                            output logic [PN-1:0] ev);
    ex = '0; ei = '0; ev = '0;
    for (int p = 0; p < PN; p++) begin
      m_grant[p] = -1;
      if (m_lock[p]) begin
        if (eff_port(m_owner[p]) == p) m_grant[p] = m_owner[p];
      end else begin
        for (int k = 0; k < N; k++) begin
          int r = (m_ptr[p] + k) % N;
          if (eff_port(r) == p) begin
            m_grant[p] = r;
            break;
          end
        end
      end
      if (m_grant[p] >= 0) begin
        ev[p] = 1'b1;
        ex[p*N + m_grant[p]] = 1'b1;
        if (out_ready[p]) ei[m_grant[p]] = 1'b1;
      end
    end
  endtask

  task automatic model_update();
    for (int p = 0; p < PN; p++) begin
      if (m_grant[p] >= 0) begin
        if (out_ready[p]) begin
          m_lock[p] = 0;
          m_ptr[p]  = (m_grant[p] + 1) % N;
        end else begin
          m_lock[p]  = 1;
          m_owner[p] = m_grant[p];
        end
      end else if (m_lock[p]) begin
        m_lock[p] = 0;
      end
    end
  endtask

  // Inputs change only at posedge+1; outputs are sampled at the falling edge.
  task automatic cycle(input string tag);
    logic [PN*N-1:0] ex;
    logic [N-1:0]    ei;
    logic [PN-1:0]   ev;
    @(negedge clk);
    model_eval(ex, ei, ev);
    obs_xbar = xbar_sel;
    obs_inr  = in_ready;
    obs_ov   = out_valid;
    check({tag, "_sel"},   64'(xbar_sel),  64'(ex));
    check({tag, "_valid"}, 64'(out_valid), 64'(ev));
    check({tag, "_ready"}, 64'(in_ready),  64'(ei));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_port  = '0;
  endtask

  task automatic set_req(input int r, input int p);
    req_valid[r]         = 1'b1;
    req_port[r*PN +: PN] = PN'(1) << p;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_rst_sel"},   64'(xbar_sel),  64'd0);
    check({tag, "_rst_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_rst_ready"}, 64'(in_ready),  64'd0);
    clear_reqs();
    out_ready = '1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    out_ready = '0;
    model_reset();
    @(posedge clk);
    #1;

    // 1: single request, then pointer lands past the winner.
    do_reset("t1");
    set_req(3, 1);
    cycle("t1a");
    check("t1_sel_p1", 64'(obs_xbar[1*N +: N]), 64'h008);
    check("t1_inr3",   64'(obs_inr[3]),         64'd1);
    set_req(5, 1);
    cycle("t1b");
    check("t1_ptr4_sel", 64'(obs_xbar[1*N +: N]), 64'h020);

    // 2: three-way contention rotates 0,4,7,0.
    do_reset("t2");
    set_req(0, 2); set_req(4, 2); set_req(7, 2);
    cycle("t2a"); check("t2_g0", 64'(obs_xbar[2*N +: N]), 64'h001);
    cycle("t2b"); check("t2_g4", 64'(obs_xbar[2*N +: N]), 64'h010);
    cycle("t2c"); check("t2_g7", 64'(obs_xbar[2*N +: N]), 64'h080);
    cycle("t2d"); check("t2_g0b", 64'(obs_xbar[2*N +: N]), 64'h001);

    // 3: back-pressure holds the grant on r=2 despite lower-index contender r=1.
    do_reset("t3");
    out_ready[0] = 1'b0;
    set_req(2, 0);
    cycle("t3a");
    set_req(1, 0);
    cycle("t3b");
    cycle("t3c");
    check("t3_hold_sel", 64'(obs_xbar[0 +: N]), 64'h004);
    check("t3_hold_inr", 64'(obs_inr), 64'd0);
    out_ready[0] = 1'b1;
    cycle("t3d");
    check("t3_fire_inr", 64'(obs_inr), 64'h004);
    req_valid[2] = 1'b0;
    cycle("t3e");
    check("t3_next_sel", 64'(obs_xbar[0 +: N]), 64'h002);

    // 4: independent outputs fire together and advance separate pointers.
    do_reset("t4");
    set_req(0, 3); set_req(5, 4);
    cycle("t4a");
    check("t4_valid", 64'(obs_ov), 64'h18);
    check("t4_inr",   64'(obs_inr), 64'h021);
    set_req(1, 3); set_req(6, 4);
    cycle("t4b");
    check("t4_p3_sel", 64'(obs_xbar[3*N +: N]), 64'h002);
    check("t4_p4_sel", 64'(obs_xbar[4*N +: N]), 64'h040);

    // 5: pointer wrap from N-1 back to 0.
    do_reset("t5");
    set_req(8, 1);
    cycle("t5a");
    clear_reqs();
    set_req(9, 1); set_req(0, 1);
    cycle("t5b"); check("t5_g9", 64'(obs_xbar[1*N +: N]), 64'h200);
    cycle("t5c"); check("t5_g0", 64'(obs_xbar[1*N +: N]), 64'h001);

    // 6: asynchronous reset while p0 is locked on r=6 with ptr=7.
    do_reset("t6");
    set_req(6, 0);
    cycle("t6a");
    out_ready[0] = 1'b0;
    cycle("t6b");
    set_req(2, 0); set_req(4, 0);
    cycle("t6c");
    check("t6_locked", 64'(obs_xbar[0 +: N]), 64'h040);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_sel",   64'(xbar_sel),  64'd0);
    check("t6_async_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    out_ready = '1;
    cycle("t6d");
    check("t6_restart", 64'(obs_xbar[0 +: N]), 64'h004);

    // Randomized traffic with sticky requests, multi-hot/zero bitmaps and back-pressure.
    do_reset("rnd");
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(3) == 0) begin
          req_valid[r] = ($urandom_range(3) != 0);
          if ($urandom_range(7) == 0) req_port[r*PN +: PN] = PN'($urandom);
          else req_port[r*PN +: PN] = PN'(1) << $urandom_range(PN - 1);
        end
      end
      out_ready = PN'($urandom) | PN'($urandom);
      if ($urandom_range(99) == 0) do_reset("rnd");
      else cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
